// File: rtl/data_mem_resp.sv
// Data-memory responder for the microcoded RV32I core: a little-endian word RAM
// that serves one two-cycle load or store per request, with lane steering and load extension.
module data_mem_resp #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  lst,
  input  logic        lu,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  typedef enum logic {
    IDLE,
    ACC
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;
  localparam logic [1:0] SZ_RSVD = 2'b10;

  state_t state, state_next;

  logic [31:0] mem [DEPTH_WORDS];

  logic             op_write;
  logic [1:0]       lst_q;
  logic             lu_q;
  logic [1:0]       off_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic             bad_q;
  logic [31:0]      rd_word;

  logic        accept;
  logic        bad;
  logic        commit;
  logic [3:0]  lane_en;
  logic [31:0] lane_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign accept = (state == IDLE) && (mem_read || mem_write);

  // A request is rejected for conflicting ops, reserved size, misalignment or an out-of-range word.
  always_comb begin
    bad = 1'b0;
    if (mem_read && mem_write) bad = 1'b1;
    case (lst)
      SZ_RSVD: bad = 1'b1;
      SZ_HALF: if (addr[0]) bad = 1'b1;
      SZ_WORD: if (addr[1:0] != 2'b00) bad = 1'b1;
      default: ;
    endcase
    if ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS)) bad = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACC;
      ACC:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      op_write <= 1'b0;
      lst_q    <= 2'b00;
      lu_q     <= 1'b0;
      off_q    <= 2'b00;
      idx_q    <= '0;
      wdata_q  <= '0;
      bad_q    <= 1'b0;
      rd_word  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_write <= mem_write;
        lst_q    <= lst;
        lu_q     <= lu;
        off_q    <= addr[1:0];
        idx_q    <= addr[IDX_W+1:2];
        wdata_q  <= wdata;
        bad_q    <= bad;
        if (mem_read && !bad) rd_word <= mem[addr[IDX_W+1:2]];
      end
    end
  end

  // Store data is replicated across lanes so the enable mask alone selects the target bytes.
  always_comb begin
    lane_en   = 4'b0000;
    lane_data = wdata_q;
    case (lst_q)
      SZ_BYTE: begin
        lane_en[off_q] = 1'b1;
        lane_data      = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        lane_en   = off_q[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_q[15:0]}};
      end
      SZ_WORD: lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  // Reset forces IDLE asynchronously, so a store interrupted in ACC never commits.
  assign commit = (state == ACC) && op_write && !bad_q;

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[idx_q][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    ld_byte = rd_word[7:0];
    case (off_q)
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = off_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (lst_q)
      SZ_BYTE: ld_ext = lu_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_ext = lu_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = rd_word;
    endcase
  end

  assign ready = (state == ACC);
  assign busy  = (state == ACC);
  assign err   = ready && bad_q;
  assign rdata = (ready && !bad_q && !op_write) ? ld_ext : 32'h0;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: a table of two-cycle accesses with
// hand-computed results, plus sequences for stay-cycle changes and reset mid-store.
module tb_data_mem_resp;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b11;
  localparam logic [1:0] SZ_R = 2'b10;

  logic        clk;
  logic        rstn;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  lst;
  logic        lu;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  lst;
    logic        lu;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  data_mem_resp #(.DEPTH_WORDS(256), .IDX_W(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .lst       (lst),
    .lu        (lu),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .err       (err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic u, input logic [31:0] a, input logic [31:0] wd,
                              input logic e, input logic [31:0] exp_d);
    vec_t v;
    v.rd = rd; v.wr = wr; v.lst = sz; v.lu = u; v.addr = a; v.wdata = wd;
    v.exp_err = e; v.exp_rdata = exp_d;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    lst       = SZ_W;
    lu        = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
  endtask

  // One access: drive in IDLE, hold through the stay cycle, check ACC then the return to IDLE.
  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    mem_read  = v.rd;
    mem_write = v.wr;
    lst       = v.lst;
    lu        = v.lu;
    addr      = v.addr;
    wdata     = v.wdata;
    @(posedge clk);
    #1;
    checkOutput({tag, " ready"}, {31'b0, ready}, 32'h1);
    checkOutput({tag, " busy"},  {31'b0, busy},  32'h1);
    checkOutput({tag, " err"},   {31'b0, err},   {31'b0, v.exp_err});
    checkOutput({tag, " rdata"}, rdata, v.exp_rdata);
    @(posedge clk);
    #1;
    idleInputs();
    checkOutput({tag, " idle ready"}, {31'b0, ready}, 32'h0);
    checkOutput({tag, " idle busy"},  {31'b0, busy},  32'h0);
  endtask

  initial begin
    idleInputs();
    rstn = 1'b0;

    vecs.push_back(mk(0, 1, SZ_W, 0, 32'h000, 32'hCAFEF00D, 0, 32'h0));
    vecs.push_back(mk(0, 1, SZ_W, 0, 32'h010, 32'hDEADBEEF, 0, 32'h0));
    vecs.push_back(mk(1, 0, SZ_W, 0, 32'h010, 32'h0,        0, 32'hDEADBEEF));
    vecs.push_back(mk(1, 0, SZ_B, 0, 32'h013, 32'h0,        0, 32'hFFFFFFDE));
    vecs.push_back(mk(1, 0, SZ_B, 1, 32'h013, 32'h0,        0, 32'h000000DE));
    vecs.push_back(mk(1, 0, SZ_H, 0, 32'h012, 32'h0,        0, 32'hFFFFDEAD));
    vecs.push_back(mk(1, 0, SZ_H, 1, 32'h010, 32'h0,        0, 32'h0000BEEF));
    vecs.push_back(mk(1, 0, SZ_B, 0, 32'h010, 32'h0,        0, 32'hFFFFFFEF));
    vecs.push_back(mk(1, 0, SZ_H, 1, 32'h012, 32'h0,        0, 32'h0000DEAD));
    vecs.push_back(mk(0, 1, SZ_B, 0, 32'h011, 32'h12345678, 0, 32'h0));
    vecs.push_back(mk(1, 0, SZ_W, 0, 32'h010, 32'h0,        0, 32'hDEAD78EF));
    vecs.push_back(mk(0, 1, SZ_H, 0, 32'h012, 32'hAAAA5555, 0, 32'h0));
    vecs.push_back(mk(1, 0, SZ_W, 0, 32'h010, 32'h0,        0, 32'h555578EF));
    vecs.push_back(mk(1, 0, SZ_B, 0, 32'h011, 32'h0,        0, 32'h00000078));
    vecs.push_back(mk(1, 0, SZ_H, 0, 32'h010, 32'h0,        0, 32'h000078EF));
    vecs.push_back(mk(1, 0, SZ_B, 1, 32'h012, 32'h0,        0, 32'h00000055));
    vecs.push_back(mk(0, 1, SZ_H, 0, 32'h011, 32'h11111111, 1, 32'h0));
    vecs.push_back(mk(1, 0, SZ_W, 0, 32'h010, 32'h0,        0, 32'h555578EF));
    vecs.push_back(mk(0, 1, SZ_W, 0, 32'h012, 32'h22222222, 1, 32'h0));
    vecs.push_back(mk(1, 0, SZ_W, 0, 32'h010, 32'h0,        0, 32'h555578EF));
    vecs.push_back(mk(1, 0, SZ_R, 0, 32'h010, 32'h0,        1, 32'h0));
    vecs.push_back(mk(1, 0, SZ_W, 0, 32'h010, 32'h0,        0, 32'h555578EF));
    vecs.push_back(mk(1, 1, SZ_W, 0, 32'h010, 32'h33333333, 1, 32'h0));
    vecs.push_back(mk(1, 0, SZ_W, 1, 32'h010, 32'h0,        0, 32'h555578EF));
    vecs.push_back(mk(0, 1, SZ_W, 0, 32'h400, 32'h99999999, 1, 32'h0));
    vecs.push_back(mk(1, 0, SZ_W, 0, 32'h010, 32'h0,        0, 32'h555578EF));
    vecs.push_back(mk(1, 0, SZ_W, 0, 32'h000, 32'h0,        0, 32'hCAFEF00D));
    vecs.push_back(mk(1, 0, SZ_W, 0, 32'h400, 32'h0,        1, 32'h0));
    vecs.push_back(mk(0, 1, SZ_W, 0, 32'h3FC, 32'h0BADCAFE, 0, 32'h0));
    vecs.push_back(mk(1, 0, SZ_W, 0, 32'h3FC, 32'h0,        0, 32'h0BADCAFE));
    vecs.push_back(mk(1, 0, SZ_H, 0, 32'h3FE, 32'h0,        0, 32'h00000BAD));

    // Reset holds outputs low even with a request present.
    mem_read = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset ready", {31'b0, ready}, 32'h0);
    checkOutput("reset busy",  {31'b0, busy},  32'h0);
    checkOutput("reset err",   {31'b0, err},   32'h0);
    checkOutput("reset rdata", rdata, 32'h0);
    idleInputs();
    @(negedge clk);
    rstn = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Stay cycle changes the store data and address: only the issue-cycle request commits.
    applyStimulus(mk(0, 1, SZ_W, 0, 32'h030, 32'h01020304, 0, 32'h0), "seqA sw");
    @(negedge clk);
    mem_write = 1'b1; lst = SZ_B; addr = 32'h030; wdata = 32'h000000AA;
    @(posedge clk);
    #1;
    checkOutput("seqA sb ready", {31'b0, ready}, 32'h1);
    wdata = 32'h000000BB; addr = 32'h031;
    @(posedge clk);
    #1;
    idleInputs();
    checkOutput("seqA sb idle busy", {31'b0, busy}, 32'h0);
    applyStimulus(mk(1, 0, SZ_W, 0, 32'h030, 32'h0, 0, 32'h010203AA), "seqA lw");

    // Reset during a store's ACC abandons the store.
    applyStimulus(mk(0, 1, SZ_W, 0, 32'h020, 32'h11111111, 0, 32'h0), "seqB sw1");
    @(negedge clk);
    mem_write = 1'b1; lst = SZ_W; addr = 32'h020; wdata = 32'h22222222;
    @(posedge clk);
    #1;
    checkOutput("seqB acc ready", {31'b0, ready}, 32'h1);
    #2;
    rstn = 1'b0;
    idleInputs();
    #1;
    checkOutput("seqB rst ready", {31'b0, ready}, 32'h0);
    checkOutput("seqB rst err",   {31'b0, err},   32'h0);
    checkOutput("seqB rst rdata", rdata, 32'h0);
    checkOutput("seqB rst busy",  {31'b0, busy},  32'h0);
    @(posedge clk);
    #2;
    rstn = 1'b1;
    applyStimulus(mk(1, 0, SZ_W, 0, 32'h020, 32'h0, 0, 32'h11111111), "seqB lw");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
